// File: rtl/bg_wipe_ctrl.sv
// Background transition controller: wipes layer_bg from the committed background
// to a requested one, moving the boundary left-to-right once per frame in vblank.
module bg_wipe_ctrl #(
    parameter int   H_VISIBLE = 640,
    parameter int   V_VISIBLE = 480,
    parameter int   STEP      = 16,
    parameter logic BG_RESET  = 1'b0
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       req,
    input  logic       target,
    output logic       bg_select,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_WIPE  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_cur;
    logic        r_tgt;
    logic        r_tick_q;
    logic [10:0] r_boundary;

    logic        w_tick_cond;
    logic        w_tick;
    logic [10:0] w_bnd_sum;
    logic        w_wipe_end;
    logic        w_accept;

    // Edge-detect the frame tick so a DrawX held at 0 on the tick line fires once.
    assign w_tick_cond = (DrawY == 10'(V_VISIBLE)) && (DrawX == 10'd0);
    assign w_tick      = w_tick_cond && !r_tick_q;
    assign w_bnd_sum   = r_boundary + 11'(STEP);
    assign w_wipe_end  = (w_bnd_sum >= 11'(H_VISIBLE));
    assign w_accept    = req && (target != r_cur);

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_nxt = w_accept ? S_ARMED : S_DONE;
                end
            end
            S_ARMED: begin
                if (w_tick) begin
                    w_state_nxt = S_WIPE;
                end
            end
            S_WIPE: begin
                if (w_tick && w_wipe_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // bg_select stays combinational on DrawX: layer_bg addresses its ROM from the same DrawX.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        bg_select = r_cur;
        case (r_state)
            S_ARMED: busy = 1'b1;
            S_WIPE: begin
                busy      = 1'b1;
                bg_select = ({1'b0, DrawX} < r_boundary) ? r_tgt : r_cur;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_cur      <= BG_RESET;
            r_tgt      <= BG_RESET;
            r_boundary <= 11'd0;
            r_tick_q   <= 1'b0;
        end else begin
            r_tick_q <= w_tick_cond;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tgt <= target;
                    end
                end
                S_ARMED: begin
                    if (w_tick) begin
                        r_boundary <= 11'(STEP);
                    end
                end
                S_WIPE: begin
                    if (w_tick) begin
                        if (w_wipe_end) begin
                            r_cur      <= r_tgt;
                            r_boundary <= 11'd0;
                        end else begin
                            r_boundary <= w_bnd_sum;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bg_wipe_ctrl.sv
// Directed bench for bg_wipe_ctrl: default 640/16 instance plus a STEP=640 instance
// sharing the scan position, with frames compressed to just the tick line.
module tb_bg_wipe_ctrl;

    logic       pixel_clk = 1'b0;
    logic       reset;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       req_a, target_a, req_b, target_b;
    logic       bg_a, busy_a, done_a;
    logic       bg_b, busy_b, done_b;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;

    always #10 pixel_clk = ~pixel_clk;

    bg_wipe_ctrl #(.H_VISIBLE(640), .V_VISIBLE(480), .STEP(16), .BG_RESET(1'b0)) u_a (
        .pixel_clk(pixel_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .req(req_a), .target(target_a),
        .bg_select(bg_a), .busy(busy_a), .done(done_a)
    );

    bg_wipe_ctrl #(.H_VISIBLE(640), .V_VISIBLE(480), .STEP(640), .BG_RESET(1'b0)) u_b (
        .pixel_clk(pixel_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .req(req_b), .target(target_b),
        .bg_select(bg_b), .busy(busy_b), .done(done_b)
    );

    always @(negedge pixel_clk) begin
        if (done_a === 1'b1) done_cnt_a++;
        if (done_b === 1'b1) done_cnt_b++;
    end

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge pixel_clk);
        #1;
    endtask

    // One compressed frame: sit on the tick position for 'hold' cycles, then leave it.
    task automatic frame_tick(input int hold);
        DrawY = 10'd480;
        DrawX = 10'd0;
        repeat (hold) sync();
        DrawX = 10'd1;
        sync();
        DrawY = 10'd0;
        DrawX = 10'd0;
    endtask

    task automatic bg_at(input string tag, input int x, input logic exp_a);
        DrawX = 10'(x);
        #1;
        chk(tag, 11'(bg_a), 11'(exp_a));
        DrawX = 10'd0;
    endtask

    initial begin
        reset = 1'b1;
        DrawX = 10'd0; DrawY = 10'd0;
        req_a = 1'b0; target_a = 1'b0; req_b = 1'b0; target_b = 1'b0;
        #2;
        chk("rst_bg_a", 11'(bg_a), 11'd0);
        chk("rst_busy_a", 11'(busy_a), 11'd0);
        chk("rst_done_a", 11'(done_a), 11'd0);
        chk("rst_bg_b", 11'(bg_b), 11'd0);
        #2 reset = 1'b0;
        sync();

        frame_tick(1);
        frame_tick(1);
        chk("idle_bg_a", 11'(bg_a), 11'd0);
        chk("idle_busy_a", 11'(busy_a), 11'd0);
        chk("idle_done_cnt", 11'(done_cnt_a), 11'd0);

        // Degenerate request: target equals committed background.
        req_a = 1'b1; target_a = 1'b0;
        sync();
        req_a = 1'b0;
        chk("degen_done", 11'(done_a), 11'd1);
        chk("degen_busy", 11'(busy_a), 11'd0);
        chk("degen_bg", 11'(bg_a), 11'd0);
        sync();
        chk("degen_done_clr", 11'(done_a), 11'd0);
        chk("degen_busy2", 11'(busy_a), 11'd0);

        // Full wipe 0 -> 1.
        req_a = 1'b1; target_a = 1'b1;
        sync();
        req_a = 1'b0;
        chk("acc_busy", 11'(busy_a), 11'd1);
        chk("acc_done", 11'(done_a), 11'd0);
        bg_at("armed_bg_x0", 0, 1'b0);
        frame_tick(1);
        bg_at("f1_x0", 0, 1'b1);
        bg_at("f1_x15", 15, 1'b1);
        bg_at("f1_x16", 16, 1'b0);
        frame_tick(3);  // DrawX held at 0 for 3 cycles: one advance only
        bg_at("f2_x31", 31, 1'b1);
        bg_at("f2_x32", 32, 1'b0);
        for (int k = 3; k <= 39; k++) begin
            frame_tick(1);
            if (k == 5) begin
                req_a = 1'b1; target_a = 1'b0;
                sync();
                req_a = 1'b0;
                chk("busy_req_ignored", 11'(busy_a), 11'd1);
                bg_at("f5_x79", 79, 1'b1);
                bg_at("f5_x80", 80, 1'b0);
            end
        end
        bg_at("f39_x623", 623, 1'b1);
        bg_at("f39_x624", 624, 1'b0);
        chk("f39_busy", 11'(busy_a), 11'd1);
        chk("f39_done_cnt", 11'(done_cnt_a), 11'd1);
        DrawY = 10'd480; DrawX = 10'd0;
        sync();
        chk("commit_done", 11'(done_a), 11'd1);
        chk("commit_busy", 11'(busy_a), 11'd0);
        DrawX = 10'd1;
        sync();
        DrawY = 10'd0;
        chk("commit_done_clr", 11'(done_a), 11'd0);
        chk("wipe_done_cnt", 11'(done_cnt_a), 11'd2);
        bg_at("after_x0", 0, 1'b1);
        bg_at("after_x639", 639, 1'b1);

        // Wipe 1 -> 0 interrupted by reset at frame 20.
        req_a = 1'b1; target_a = 1'b0;
        sync();
        req_a = 1'b0;
        for (int k = 1; k <= 20; k++) frame_tick(1);
        bg_at("mid_x319", 319, 1'b0);
        bg_at("mid_x320", 320, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("mrst_busy", 11'(busy_a), 11'd0);
        chk("mrst_done", 11'(done_a), 11'd0);
        bg_at("mrst_x0", 0, 1'b0);
        bg_at("mrst_x639", 639, 1'b0);
        #1 reset = 1'b0;
        sync();
        chk("mrst_done_cnt", 11'(done_cnt_a), 11'd2);
        chk("mrst_busy2", 11'(busy_a), 11'd0);

        // Fresh request after reset takes the full 40 ticks.
        req_a = 1'b1; target_a = 1'b1;
        sync();
        req_a = 1'b0;
        for (int k = 1; k <= 39; k++) frame_tick(1);
        chk("fresh39_busy", 11'(busy_a), 11'd1);
        chk("fresh39_done_cnt", 11'(done_cnt_a), 11'd2);
        bg_at("fresh39_x624", 624, 1'b0);
        frame_tick(1);
        chk("fresh40_done_cnt", 11'(done_cnt_a), 11'd3);
        chk("fresh40_busy", 11'(busy_a), 11'd0);
        bg_at("fresh40_x639", 639, 1'b1);

        // STEP=640 instance, request landing in the same cycle as a tick.
        DrawY = 10'd480; DrawX = 10'd0;
        req_b = 1'b1; target_b = 1'b1;
        sync();
        req_b = 1'b0;
        chk("b_acc_busy", 11'(busy_b), 11'd1);
        chk("b_armed_bg", 11'(bg_b), 11'd0);
        DrawX = 10'd1;
        sync();
        DrawY = 10'd0; DrawX = 10'd0;
        frame_tick(1);
        chk("b_wipe_busy", 11'(busy_b), 11'd1);
        DrawX = 10'd639;
        #1;
        chk("b_wipe_x639", 11'(bg_b), 11'd1);
        DrawX = 10'd0;
        chk("b_done_cnt_pre", 11'(done_cnt_b), 11'd0);
        DrawY = 10'd480;
        sync();
        chk("b_commit_done", 11'(done_b), 11'd1);
        chk("b_commit_busy", 11'(busy_b), 11'd0);
        DrawX = 10'd1;
        sync();
        DrawY = 10'd0; DrawX = 10'd0;
        chk("b_done_cnt", 11'(done_cnt_b), 11'd1);
        chk("b_final_bg", 11'(bg_b), 11'd1);
        chk("a_untouched_cnt", 11'(done_cnt_a), 11'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
